pll_lock_ctrl: RTL and testbench

//  Sits on the PLL's refclk/rst/locked interface and owns the PLL from the core side.

---
 rtl/pll_lock_ctrl_if.sv | 17 +
 rtl/pll_lock_ctrl.sv | 97 +++++++++
 tb/tb_pll_lock_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if: PLL and core-side control signals of pll_lock_ctrl; lock_loss_cnt only with PLL_LOCK_STATS_EN
interface pll_lock_ctrl_if;
    logic pll_locked;
    logic relock_req;
    logic pll_rst;
    logic core_rst_n;
    logic ready;
    logic timeout_err;
`ifdef PLL_LOCK_STATS_EN
    logic [7:0] lock_loss_cnt;
    modport master (input pll_locked, relock_req, output pll_rst, core_rst_n, ready, timeout_err, lock_loss_cnt);
    modport slave (output pll_locked, relock_req, input pll_rst, core_rst_n, ready, timeout_err, lock_loss_cnt);
`else
    modport master (input pll_locked, relock_req, output pll_rst, core_rst_n, ready, timeout_err);
    modport slave (output pll_locked, relock_req, input pll_rst, core_rst_n, ready, timeout_err);
`endif
endinterface

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset sequencing, lock qualification and core reset release; lock-loss counter with PLL_LOCK_STATS_EN
module pll_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic             refclk,
    input logic             rst_n,
    pll_lock_ctrl_if.master bus
);
    localparam int MAXP = (RST_CYCLES > STABLE_CYCLES)
                        ? ((RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES)
                        : ((STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES);
    localparam int W = $clog2(MAXP) + 1;
    localparam logic [W-1:0] RST_LAST = W'(RST_CYCLES - 1);
    localparam logic [W-1:0] STB_LAST = W'(STABLE_CYCLES - 1);
    localparam logic [W-1:0] TO_LAST  = W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RESET_PLL = 2'd0;
    localparam logic [1:0] WAIT_LOCK = 2'd1;
    localparam logic [1:0] STABLE    = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    logic [1:0]   st, st_n;
    logic [W-1:0] cnt, cnt_n;
    logic         sync1, locked_s, timeout;
    logic         pll_rst_q, core_rst_q, ready_q, terr_q;

    // Next state; one shared counter serves as reset, timeout and stable-sample count
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        timeout = (st == WAIT_LOCK) && !locked_s && (cnt == TO_LAST);
        if (bus.relock_req) begin
            st_n  = RESET_PLL;
            cnt_n = '0;
        end else begin
            case (st)
                RESET_PLL: begin
                    st_n  = (cnt == RST_LAST) ? WAIT_LOCK : RESET_PLL;
                    cnt_n = (cnt == RST_LAST) ? '0 : cnt + 1'b1;
                end
                WAIT_LOCK: begin
                    st_n  = locked_s ? ((STABLE_CYCLES == 1) ? RUN : STABLE) : (timeout ? RESET_PLL : WAIT_LOCK);
                    cnt_n = locked_s ? W'(1) : (timeout ? '0 : cnt + 1'b1);
                end
                STABLE: begin
                    st_n  = !locked_s ? WAIT_LOCK : ((cnt == STB_LAST) ? RUN : STABLE);
                    cnt_n = (!locked_s || cnt == STB_LAST) ? '0 : cnt + 1'b1;
                end
                default: begin
                    st_n  = locked_s ? RUN : RESET_PLL;
                    cnt_n = '0;
                end
            endcase
        end
    end

    // Synchroniser, state and registered outputs derived from the next state so they change on the transition edge
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            locked_s   <= 1'b0;
            st         <= RESET_PLL;
            cnt        <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b0;
            ready_q    <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            sync1      <= bus.pll_locked;
            locked_s   <= sync1;
            st         <= st_n;
            cnt        <= cnt_n;
            pll_rst_q  <= (st_n == RESET_PLL);
            core_rst_q <= (st_n == RUN);
            ready_q    <= (st_n == RUN);
            terr_q     <= terr_q | timeout;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.core_rst_n  = core_rst_q;
    assign bus.ready       = ready_q;
    assign bus.timeout_err = terr_q;

`ifdef PLL_LOCK_STATS_EN
    logic [7:0] loss_cnt;

    // Count RUN exits caused by lock loss, saturating at 255
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) loss_cnt <= 8'd0;
        else if (st == RUN && !locked_s && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end

    assign bus.lock_loss_cnt = loss_cnt;
`endif
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed and randomized checks of pll_lock_ctrl against a behavioural model
module tb_pll_lock_ctrl;
    localparam int RST = 4;
    localparam int STB = 8;
    localparam int TO  = 32;

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   passed = 0;

    pll_lock_ctrl_if bus ();

    pll_lock_ctrl #(.RST_CYCLES(RST), .STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TO)) dut (
        .refclk(refclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    // Behavioural model: phase plus elapsed-time bookkeeping
    typedef enum {M_RST, M_WAIT, M_STB, M_RUN} phase_t;
    phase_t m_phase;
    int     m_rleft, m_age, m_good, m_loss;
    logic   m_terr, m_h1, m_h2;

    task automatic model_reset();
        m_phase = M_RST; m_rleft = RST; m_age = 0; m_good = 0;
        m_loss = 0; m_terr = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
    endtask

    task automatic model_edge();
        logic ls;
        logic r;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = m_h2; m_h2 = m_h1; m_h1 = bus.pll_locked; r = bus.relock_req;
        case (m_phase)
            M_RST: begin
                if (r) m_rleft = RST;
                else begin
                    m_rleft--;
                    if (m_rleft == 0) begin m_phase = M_WAIT; m_age = 0; end
                end
            end
            M_WAIT: begin
                if (!ls && m_age == TO - 1) begin m_terr = 1'b1; m_phase = M_RST; m_rleft = RST; end
                else if (r) begin m_phase = M_RST; m_rleft = RST; end
                else if (ls) begin m_good = 1; m_phase = (m_good == STB) ? M_RUN : M_STB; end
                else m_age++;
            end
            M_STB: begin
                if (r) begin m_phase = M_RST; m_rleft = RST; end
                else if (!ls) begin m_phase = M_WAIT; m_age = 0; end
                else begin m_good++; if (m_good == STB) m_phase = M_RUN; end
            end
            default: begin
                if (!ls) begin m_loss = (m_loss < 255) ? m_loss + 1 : 255; m_phase = M_RST; m_rleft = RST; end
                else if (r) begin m_phase = M_RST; m_rleft = RST; end
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
    endtask

    task automatic sync_reset();
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic go_run(input string name);
        int n;
        bus.pll_locked = 1'b1;
        n = 0;
        while (!bus.ready && n < 60) begin cyc(); n++; end
        total++;
        if (bus.ready !== 1'b1) $display("FAIL %s ready=%b required=1 within 60 cycles", name, bus.ready);
        else passed++;
    endtask

    task automatic test_reset();
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        model_reset();
        cyc();
        cyc();
        total += 4;
        if (bus.pll_rst !== 1'b1) $display("FAIL reset_pll_rst got=%b exp=1", bus.pll_rst); else passed++;
        if (bus.core_rst_n !== 1'b0) $display("FAIL reset_core_rst_n got=%b exp=0", bus.core_rst_n); else passed++;
        if (bus.ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.ready); else passed++;
        if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%b exp=0", bus.timeout_err); else passed++;
`ifdef PLL_LOCK_STATS_EN
        total++;
        if (bus.lock_loss_cnt !== 8'd0) $display("FAIL reset_loss got=%0d exp=0", bus.lock_loss_cnt); else passed++;
`endif
    endtask

    task automatic test_rst_pulse();
        rst_n = 1'b1;
        for (int i = 1; i <= RST; i++) begin
            cyc();
            total++;
            if (bus.pll_rst !== (i < RST)) $display("FAIL rst_pulse edge%0d got=%b exp=%b", i, bus.pll_rst, i < RST);
            else passed++;
        end
        total++;
        if ({bus.core_rst_n, bus.ready} !== 2'b00) $display("FAIL rst_pulse_core got=%b exp=00", {bus.core_rst_n, bus.ready});
        else passed++;
    endtask

    task automatic test_lock();
        cyc();
        cyc();
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= STB + 2; i++) begin
            cyc();
            total++;
            if ({bus.core_rst_n, bus.ready} !== {2{i == STB + 2}})
                $display("FAIL lock_latency edge%0d got=%b exp=%b", i, {bus.core_rst_n, bus.ready}, {2{i == STB + 2}});
            else passed++;
        end
        total++;
        if (bus.timeout_err !== 1'b0) $display("FAIL lock_timeout_err got=%b exp=0", bus.timeout_err); else passed++;
    endtask

    task automatic test_glitch();
        sync_reset();
        repeat (RST) cyc();
        bus.pll_locked = 1'b1;
        repeat (7) cyc();
        bus.pll_locked = 1'b0;
        cyc();
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= STB + 2; i++) begin
            cyc();
            total++;
            if (bus.ready !== (i == STB + 2)) $display("FAIL glitch_release edge%0d got=%b exp=%b", i, bus.ready, i == STB + 2);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        sync_reset();
        repeat (RST) cyc();
        for (int i = 1; i <= TO; i++) begin
            cyc();
            total++;
            if (bus.timeout_err !== (i == TO)) $display("FAIL timeout edge%0d got=%b exp=%b", i, bus.timeout_err, i == TO);
            else passed++;
        end
        total++;
        if (bus.pll_rst !== 1'b1) $display("FAIL timeout_pll_rst got=%b exp=1", bus.pll_rst); else passed++;
        for (int i = 1; i <= RST; i++) begin
            cyc();
            total++;
            if (bus.pll_rst !== (i < RST)) $display("FAIL timeout_repulse edge%0d got=%b exp=%b", i, bus.pll_rst, i < RST);
            else passed++;
        end
        bus.pll_locked = 1'b1;
        for (int i = 1; i <= STB + 2; i++) begin
            cyc();
            total++;
            if (bus.ready !== (i == STB + 2)) $display("FAIL timeout_relock edge%0d got=%b exp=%b", i, bus.ready, i == STB + 2);
            else passed++;
        end
        total++;
        if (bus.timeout_err !== 1'b1) $display("FAIL timeout_sticky got=%b exp=1", bus.timeout_err); else passed++;
    endtask

    task automatic test_lock_loss();
        bus.pll_locked = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            total++;
            if (bus.core_rst_n !== (i < 3)) $display("FAIL loss_core edge%0d got=%b exp=%b", i, bus.core_rst_n, i < 3);
            else passed++;
        end
        total++;
        if (bus.pll_rst !== 1'b1) $display("FAIL loss_pll_rst got=%b exp=1", bus.pll_rst); else passed++;
        for (int i = 1; i <= RST; i++) begin
            cyc();
            total++;
            if (bus.pll_rst !== (i < RST)) $display("FAIL loss_repulse edge%0d got=%b exp=%b", i, bus.pll_rst, i < RST);
            else passed++;
        end
`ifdef PLL_LOCK_STATS_EN
        total++;
        if (bus.lock_loss_cnt !== 8'd1) $display("FAIL loss_count got=%0d exp=1", bus.lock_loss_cnt); else passed++;
`endif
    endtask

    task automatic test_relock();
        go_run("relock_pre_run");
        bus.relock_req = 1'b1;
        cyc();
        bus.relock_req = 1'b0;
        total++;
        if ({bus.ready, bus.core_rst_n, bus.pll_rst} !== 3'b001)
            $display("FAIL relock_drop got=%b exp=001", {bus.ready, bus.core_rst_n, bus.pll_rst});
        else passed++;
        for (int i = 1; i <= RST; i++) begin
            cyc();
            total++;
            if (bus.pll_rst !== (i < RST)) $display("FAIL relock_pulse edge%0d got=%b exp=%b", i, bus.pll_rst, i < RST);
            else passed++;
        end
        go_run("relock_post_run");
`ifdef PLL_LOCK_STATS_EN
        total++;
        if (bus.lock_loss_cnt !== 8'd1) $display("FAIL relock_loss_count got=%0d exp=1", bus.lock_loss_cnt); else passed++;
`endif
    endtask

    task automatic test_saturation();
`ifdef PLL_LOCK_STATS_EN
        for (int i = 0; i < 300; i++) begin
            go_run("sat_run");
            bus.pll_locked = 1'b0;
            repeat (3) cyc();
        end
        total += 2;
        if (bus.lock_loss_cnt !== 8'hFF) $display("FAIL sat_count got=%0d exp=255", bus.lock_loss_cnt); else passed++;
        if (int'(bus.lock_loss_cnt) !== m_loss) $display("FAIL sat_model got=%0d exp=%0d", bus.lock_loss_cnt, m_loss); else passed++;
`endif
    endtask

    task automatic test_async_reset();
        go_run("async_pre_run");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if ({bus.pll_rst, bus.core_rst_n, bus.ready, bus.timeout_err} !== 4'b1000)
            $display("FAIL async_reset got=%b exp=1000", {bus.pll_rst, bus.core_rst_n, bus.ready, bus.timeout_err});
        else passed++;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int len;
        logic lvl;
        sync_reset();
        for (int n = 0; n < 2500;) begin
            lvl = ($urandom_range(0, 3) != 0);
            len = lvl ? $urandom_range(1, 30) : $urandom_range(1, 45);
            bus.pll_locked = lvl;
            for (int k = 0; k < len; k++) begin
                bus.relock_req = ($urandom_range(0, 39) == 0);
                cyc();
                n++;
                total++;
                if ({bus.pll_rst, bus.core_rst_n, bus.ready, bus.timeout_err} !==
                    {m_phase == M_RST, m_phase == M_RUN, m_phase == M_RUN, m_terr})
                    $display("FAIL random cycle%0d got=%b exp=%b", n, {bus.pll_rst, bus.core_rst_n, bus.ready, bus.timeout_err},
                             {m_phase == M_RST, m_phase == M_RUN, m_phase == M_RUN, m_terr});
                else passed++;
`ifdef PLL_LOCK_STATS_EN
                total++;
                if (int'(bus.lock_loss_cnt) !== m_loss) $display("FAIL random_loss cycle%0d got=%0d exp=%0d", n, bus.lock_loss_cnt, m_loss);
                else passed++;
`endif
            end
        end
        bus.relock_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rst_pulse();
        test_lock();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_relock();
        test_saturation();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
